// File: rtl/sched_ws_pkg.sv
// Shared state encodings and defaults for the wait-state phase scheduler.
package sched_ws_pkg;

    localparam int WS_W_DEF = 4;

    localparam logic [2:0] ST_RST  = 3'd0;
    localparam logic [2:0] ST_F    = 3'd1;
    localparam logic [2:0] ST_E    = 3'd2;
    localparam logic [2:0] ST_M    = 3'd3;
    localparam logic [2:0] ST_W    = 3'd4;
    localparam logic [2:0] ST_HALT = 3'd5;
    localparam logic [2:0] ST_WAIT = 3'd6;

    typedef enum logic [2:0] {
        S_RST, S_F, S_E, S_M, S_W, S_HALT
    } state_t;

endpackage

// File: rtl/sched_ws_wait_ctr.sv
// Bus-phase wait counter: load on phase entry, count down to zero.
module sched_ws_wait_ctr #(
    parameter int WS_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [WS_W-1:0] load_val,
    input  logic            dec,
    output logic            zero
);
    logic [WS_W-1:0] wc;

    always_ff @(posedge clk) begin
        if (reset)
            wc <= '0;
        else if (load)
            wc <= load_val;
        else if (dec && wc != '0)
            wc <= wc - 1'b1;
    end

    assign zero = (wc == '0);
endmodule

// File: rtl/sched_ws.sv
// Four-phase F/E/M/W scheduler with bus wait states, ready handshake,
// MEM skip, halt/single-step and cycle/retire counters.
module sched_ws
    import sched_ws_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int WS_W  = WS_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WS_W-1:0]  wait_cfg,
    input  logic             mem_ready,
    input  logic             skip_mem,
    input  logic             halt,
    input  logic             step,
    output logic             phf,
    output logic             phe,
    output logic             phm,
    output logic             phw,
    output logic             phf_end,
    output logic             phm_end,
    output logic             halted,
    output logic [WIDTH-1:0] cyc_cnt,
    output logic [WIDTH-1:0] ret_cnt,
    output logic [2:0]       clk_stat
);
    state_t state, state_nxt;
    logic   wc_zero, wc_load, wc_dec, bus_done;

    sched_ws_wait_ctr #(.WS_W(WS_W)) u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (wc_load),
        .load_val (wait_cfg),
        .dec      (wc_dec),
        .zero     (wc_zero)
    );

    // mem_ready only matters once the programmed waits have elapsed; this is
    // the one combinational input-to-output path (into *_end).
    assign bus_done = wc_zero && mem_ready && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_RST;
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state != S_HALT)
                cyc_cnt <= cyc_cnt + 1'b1;
            if (state == S_W)
                ret_cnt <= ret_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:  state_nxt = S_F;
            S_F:    if (bus_done) state_nxt = S_E;
            S_E:    state_nxt = skip_mem ? S_W : S_M;
            S_M:    if (bus_done) state_nxt = S_W;
            S_W:    state_nxt = halt ? S_HALT : S_F;
            S_HALT: if (step || !halt) state_nxt = S_F;
            default: state_nxt = S_RST;
        endcase
    end

    assign wc_load = (state_nxt == S_F && state != S_F) ||
                     (state_nxt == S_M && state != S_M);
    assign wc_dec  = (state == S_F) || (state == S_M);

    always_comb begin
        phf      = 1'b0;
        phe      = 1'b0;
        phm      = 1'b0;
        phw      = 1'b0;
        halted   = 1'b0;
        clk_stat = ST_RST;
        case (state)
            S_F:    begin phf = 1'b1; clk_stat = wc_zero ? ST_F : ST_WAIT; end
            S_E:    begin phe = 1'b1; clk_stat = ST_E; end
            S_M:    begin phm = 1'b1; clk_stat = wc_zero ? ST_M : ST_WAIT; end
            S_W:    begin phw = 1'b1; clk_stat = ST_W; end
            S_HALT: begin halted = 1'b1; clk_stat = ST_HALT; end
            default: ;
        endcase
    end

    assign phf_end = phf && bus_done;
    assign phm_end = phm && bus_done;
endmodule

// File: tb/tb_sched_ws.sv
// Directed bench for sched_ws: timing, waits, handshake, skip, halt/step, reset.
module tb_sched_ws;
    localparam int WIDTH = 32;
    localparam int WS_W  = 4;

    logic             clk = 1'b0;
    logic             reset, mem_ready, skip_mem, halt, step;
    logic [WS_W-1:0]  wait_cfg;
    logic             phf, phe, phm, phw, phf_end, phm_end, halted;
    logic [WIDTH-1:0] cyc_cnt, ret_cnt;
    logic [2:0]       clk_stat;

    int total = 0;
    int bad   = 0;

    sched_ws #(.WIDTH(WIDTH), .WS_W(WS_W)) dut (
        .clk(clk), .reset(reset), .wait_cfg(wait_cfg), .mem_ready(mem_ready),
        .skip_mem(skip_mem), .halt(halt), .step(step),
        .phf(phf), .phe(phe), .phm(phm), .phw(phw),
        .phf_end(phf_end), .phm_end(phm_end), .halted(halted),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .clk_stat(clk_stat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        #0;
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks phase flags, end strobes and state code of the current cycle.
    task automatic chk_ph(input string tag, input logic [3:0] ph, input logic [1:0] ends,
                          input logic [2:0] st);
        chk({tag, ".ph"},   {phf, phe, phm, phw}, ph);
        chk({tag, ".end"},  {phf_end, phm_end}, ends);
        chk({tag, ".stat"}, clk_stat, st);
    endtask

    initial begin
        reset = 1'b1; wait_cfg = '0; mem_ready = 1'b1;
        skip_mem = 1'b0; halt = 1'b0; step = 1'b0;
        tick(); tick();
        chk_ph("reset", 4'b0000, 2'b00, 3'd0);
        chk("reset.cyc", cyc_cnt, 0);
        chk("reset.ret", ret_cnt, 0);
        chk("reset.halted", halted, 0);

        // Base timing: three single-cycle-phase instructions
        reset = 1'b0;
        chk("rst_exit.stat", clk_stat, 3'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk_ph("base.F", 4'b1000, 2'b10, 3'd1); tick();
            chk_ph("base.E", 4'b0100, 2'b00, 3'd2); tick();
            chk_ph("base.M", 4'b0010, 2'b01, 3'd3); tick();
            chk_ph("base.W", 4'b0001, 2'b00, 3'd4); tick();
        end
        chk("base.ret", ret_cnt, 3);
        chk("base.cyc", cyc_cnt, 13);

        // Skip MEM: E goes straight to W
        chk_ph("skip.F", 4'b1000, 2'b10, 3'd1); tick();
        skip_mem = 1'b1;
        chk_ph("skip.E", 4'b0100, 2'b00, 3'd2); tick();
        skip_mem = 1'b0;
        chk_ph("skip.W", 4'b0001, 2'b00, 3'd4);
        wait_cfg = 4'd2;
        tick();
        chk("skip.cyc", cyc_cnt, 16);
        chk("skip.ret", ret_cnt, 4);

        // Two wait states on F and M
        chk_ph("ws.F0", 4'b1000, 2'b00, 3'd6); tick();
        chk_ph("ws.F1", 4'b1000, 2'b00, 3'd6); tick();
        chk_ph("ws.F2", 4'b1000, 2'b10, 3'd1); tick();
        chk_ph("ws.E",  4'b0100, 2'b00, 3'd2); tick();
        chk_ph("ws.M0", 4'b0010, 2'b00, 3'd6); tick();
        chk_ph("ws.M1", 4'b0010, 2'b00, 3'd6); tick();
        chk_ph("ws.M2", 4'b0010, 2'b01, 3'd3); tick();
        chk_ph("ws.W",  4'b0001, 2'b00, 3'd4);
        wait_cfg = 4'd0;
        tick();
        chk("ws.cyc", cyc_cnt, 24);
        chk("ws.ret", ret_cnt, 5);

        // Ready handshake: mem_ready low for 4 MEM cycles
        tick(); tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_ph("rdy.Mwait", 4'b0010, 2'b00, 3'd3); tick();
        end
        mem_ready = 1'b1;
        chk_ph("rdy.Mend", 4'b0010, 2'b01, 3'd3); tick();
        chk_ph("rdy.W", 4'b0001, 2'b00, 3'd4); tick();
        chk_ph("rdy.F", 4'b1000, 2'b10, 3'd1);
        chk("rdy.cyc", cyc_cnt, 32);
        chk("rdy.ret", ret_cnt, 6);

        // Halt raised in M: instruction completes, then HALT with frozen cycles
        tick(); tick();
        halt = 1'b1;
        tick();
        chk_ph("halt.W", 4'b0001, 2'b00, 3'd4); tick();
        chk_ph("halt.H", 4'b0000, 2'b00, 3'd5);
        chk("halt.halted", halted, 1);
        for (int i = 0; i < 10; i++) tick();
        chk("halt.cyc_frozen", cyc_cnt, 36);
        chk("halt.ret", ret_cnt, 7);

        // Single step with halt still high
        step = 1'b1;
        tick();
        step = 1'b0;
        chk_ph("step.F", 4'b1000, 2'b10, 3'd1); tick();
        chk_ph("step.E", 4'b0100, 2'b00, 3'd2); tick();
        tick();
        chk_ph("step.W", 4'b0001, 2'b00, 3'd4); tick();
        chk("step.halted", halted, 1);
        chk("step.ret", ret_cnt, 8);
        chk("step.cyc", cyc_cnt, 40);
        halt = 1'b0;
        tick();
        chk_ph("resume.F", 4'b1000, 2'b10, 3'd1);
        chk("resume.halted", halted, 0);

        // Reset during a stretched FETCH
        wait_cfg = 4'd2;
        tick(); tick();
        chk_ph("pre.M0", 4'b0010, 2'b00, 3'd6); tick(); tick(); tick();
        chk_ph("pre.W", 4'b0001, 2'b00, 3'd4); tick();
        chk_ph("pre.Fwait", 4'b1000, 2'b00, 3'd6);
        reset = 1'b1;
        chk("rstmid.no_end", phf_end, 0);
        tick();
        chk_ph("rstmid", 4'b0000, 2'b00, 3'd0);
        chk("rstmid.cyc", cyc_cnt, 0);
        chk("rstmid.ret", ret_cnt, 0);
        reset = 1'b0;
        tick();
        chk_ph("reload.F0", 4'b1000, 2'b00, 3'd6);
        chk("reload.cyc", cyc_cnt, 1);
        tick(); tick();
        chk_ph("reload.F2", 4'b1000, 2'b10, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
